// File: rtl/rijndael_shiftrows_stage_pkg.sv
// Shared Rijndael ShiftRows helpers: row offsets, byte placement and the legal-NB check.
package aes_pkg;

    localparam int unsigned ROWS = 4;

    // Bit n set means NB = n is a supported Rijndael block width.
    localparam int unsigned NB_LEGAL_MASK = (1 << 4) | (1 << 6) | (1 << 8);

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

    function automatic bit nb_legal(input int unsigned nb);
        return (nb <= 8) && (((NB_LEGAL_MASK >> nb) & 1) != 0);
    endfunction

    // Rows 2 and 3 shift one extra column for the 256-bit block.
    function automatic int unsigned shift_offset(input int unsigned nb, input int unsigned row);
        if ((nb == 8) && (row >= 2)) begin
            return row + 1;
        end
        return row;
    endfunction

    // Byte 0 sits in the MSBs; bytes are laid out column-major.
    function automatic int unsigned byte_lsb(input int unsigned nb, input int unsigned r,
                                             input int unsigned c);
        return 32 * nb - 8 - 8 * (ROWS * c + r);
    endfunction

endpackage

// File: rtl/rijndael_shiftrows_stage_if.sv
// Stream bundle for the ShiftRows stage: input beat, output beat and flush.
interface rijndael_shiftrows_stage_if #(
    parameter int unsigned NB    = 4,
    parameter int unsigned TAG_W = 4
) ();

    logic                flush;
    logic                in_valid;
    logic                in_ready;
    logic                in_inverse;
    logic [32*NB-1:0]    in_state;
    logic [TAG_W-1:0]    in_tag;
    logic                out_valid;
    logic                out_ready;
    logic [32*NB-1:0]    out_state;
    logic [TAG_W-1:0]    out_tag;

    modport master (
        output flush, in_valid, in_inverse, in_state, in_tag, out_ready,
        input  in_ready, out_valid, out_state, out_tag
    );

    modport slave (
        input  flush, in_valid, in_inverse, in_state, in_tag, out_ready,
        output in_ready, out_valid, out_state, out_tag
    );

endinterface

// File: rtl/rijndael_shiftrows_stage_perm.sv
// Combinational ShiftRows / InvShiftRows for Nb = 4, 6 or 8 columns.
module rijndael_shiftrows_perm
    import aes_pkg::*;
#(
    parameter int unsigned NB = 4
) (
    input  logic [32*NB-1:0] state_i,
    input  logic             inverse_i,
    output logic [32*NB-1:0] state_o
);

    always_comb begin
        state_o = '0;
        for (int unsigned c = 0; c < NB; c++) begin
            for (int unsigned r = 0; r < ROWS; r++) begin
                if (inverse_i) begin
                    state_o[byte_lsb(NB, r, c) +: 8] =
                        state_i[byte_lsb(NB, r, (c + NB - shift_offset(NB, r)) % NB) +: 8];
                end else begin
                    state_o[byte_lsb(NB, r, c) +: 8] =
                        state_i[byte_lsb(NB, r, (c + shift_offset(NB, r)) % NB) +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/rijndael_shiftrows_stage.sv
// Registered ShiftRows stage with a two-entry elastic output (main + skid register).
module rijndael_shiftrows_stage
    import aes_pkg::*;
#(
    parameter int unsigned NB    = 4,
    parameter int unsigned TAG_W = 4
) (
    input logic                    clk,
    input logic                    rst_n,
    rijndael_shiftrows_stage_if.slave bus
);

    if (!nb_legal(NB)) begin : g_bad_nb
        $error("rijndael_shiftrows_stage: NB must be 4, 6 or 8");
    end
    if (TAG_W < 1) begin : g_bad_tag
        $error("rijndael_shiftrows_stage: TAG_W must be at least 1");
    end

    logic [32*NB-1:0] perm_state;

    occ_e             occ_q, occ_d;
    logic [32*NB-1:0] main_state_q, main_state_d;
    logic [TAG_W-1:0] main_tag_q, main_tag_d;
    logic [32*NB-1:0] skid_state_q, skid_state_d;
    logic [TAG_W-1:0] skid_tag_q, skid_tag_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic in_acc;
    logic out_acc;

    rijndael_shiftrows_perm #(
        .NB(NB)
    ) u_perm (
        .state_i  (bus.in_state),
        .inverse_i(bus.in_inverse),
        .state_o  (perm_state)
    );

    assign in_acc  = bus.in_valid && in_ready_q;
    assign out_acc = out_valid_q && bus.out_ready;

    always_comb begin
        occ_d        = occ_q;
        main_state_d = main_state_q;
        main_tag_d   = main_tag_q;
        skid_state_d = skid_state_q;
        skid_tag_d   = skid_tag_q;
        if (bus.flush) begin
            occ_d        = OCC_EMPTY;
            main_state_d = '0;
            main_tag_d   = '0;
            skid_state_d = '0;
            skid_tag_d   = '0;
        end else begin
            case (occ_q)
                OCC_EMPTY: begin
                    if (in_acc) begin
                        main_state_d = perm_state;
                        main_tag_d   = bus.in_tag;
                        occ_d        = OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (in_acc && out_acc) begin
                        main_state_d = perm_state;
                        main_tag_d   = bus.in_tag;
                    end else if (in_acc) begin
                        skid_state_d = perm_state;
                        skid_tag_d   = bus.in_tag;
                        occ_d        = OCC_TWO;
                    end else if (out_acc) begin
                        occ_d = OCC_EMPTY;
                    end
                end
                OCC_TWO: begin
                    // in_ready is low here, so only the drain path can move.
                    if (out_acc) begin
                        main_state_d = skid_state_q;
                        main_tag_d   = skid_tag_q;
                        occ_d        = OCC_ONE;
                    end
                end
                default: occ_d = OCC_EMPTY;
            endcase
        end
        in_ready_d  = (occ_d != OCC_TWO);
        out_valid_d = (occ_d != OCC_EMPTY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q        <= OCC_EMPTY;
            main_state_q <= '0;
            main_tag_q   <= '0;
            skid_state_q <= '0;
            skid_tag_q   <= '0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
        end else begin
            occ_q        <= occ_d;
            main_state_q <= main_state_d;
            main_tag_q   <= main_tag_d;
            skid_state_q <= skid_state_d;
            skid_tag_q   <= skid_tag_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_state = main_state_q;
    assign bus.out_tag   = main_tag_q;

endmodule

// File: tb/tb_rijndael_shiftrows_stage.sv
// Randomised bench for rijndael_shiftrows_stage against a row/column byte-array model.
module tb_rijndael_shiftrows_stage;

    localparam int unsigned TAG_W = 4;
    localparam logic [127:0] FIPS_IN  = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] FIPS_OUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rijndael_shiftrows_stage_if #(.NB(4), .TAG_W(TAG_W)) bus4 ();
    rijndael_shiftrows_stage_if #(.NB(6), .TAG_W(TAG_W)) bus6 ();
    rijndael_shiftrows_stage_if #(.NB(8), .TAG_W(TAG_W)) bus8 ();

    rijndael_shiftrows_stage #(.NB(4), .TAG_W(TAG_W)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
    rijndael_shiftrows_stage #(.NB(6), .TAG_W(TAG_W)) u_dut6 (.clk(clk), .rst_n(rst_n), .bus(bus6));
    rijndael_shiftrows_stage #(.NB(8), .TAG_W(TAG_W)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Model: unpack into a 4 x nb byte grid, rotate each row, repack column-major.
    function automatic logic [255:0] ref_shift(input int unsigned nb, input bit inv,
                                               input logic [255:0] s);
        logic [7:0]   grid [4][8];
        int unsigned  offs [4];
        int unsigned  src;
        logic [255:0] res;
        for (int unsigned r = 0; r < 4; r++) offs[r] = (nb == 8 && r >= 2) ? r + 1 : r;
        for (int unsigned c = 0; c < nb; c++)
            for (int unsigned r = 0; r < 4; r++)
                grid[r][c] = s[8 * (4 * nb - 1 - (4 * c + r)) +: 8];
        res = '0;
        for (int unsigned c = 0; c < nb; c++)
            for (int unsigned r = 0; r < 4; r++) begin
                src = inv ? (c + nb - offs[r]) % nb : (c + offs[r]) % nb;
                res = (res << 8) | {248'b0, grid[r][src]};
            end
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [127:0]     st;
    } exp_t;

    exp_t             sb_q[$];
    logic [TAG_W-1:0] seen_tags[$];
    exp_t             m_e;
    logic [255:0]     m_full;
    logic             prev_stall = 1'b0;
    logic [127:0]     prev_st;
    logic [TAG_W-1:0] prev_tag;

    // Scoreboard for the NB=4 instance; handshakes are judged at the negedge before each edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb_q.delete();
            prev_stall = 1'b0;
        end else begin
            chk("out_valid_vs_occupancy", bus4.out_valid, sb_q.size() > 0);
            chk("in_ready_vs_occupancy", bus4.in_ready, sb_q.size() < 2);
            if (prev_stall) begin
                chk("stall_state_stable", bus4.out_state, prev_st);
                chk("stall_tag_stable", bus4.out_tag, prev_tag);
            end
            prev_stall = bus4.out_valid && !bus4.out_ready && !bus4.flush;
            prev_st    = bus4.out_state;
            prev_tag   = bus4.out_tag;
            if (bus4.flush) begin
                sb_q.delete();
            end else begin
                if (bus4.out_valid && bus4.out_ready) begin
                    chk("pop_has_expected", sb_q.size() != 0, 1);
                    if (sb_q.size() != 0) begin
                        m_e = sb_q.pop_front();
                        chk("out_state", bus4.out_state, m_e.st);
                        chk("out_tag", bus4.out_tag, m_e.tag);
                        seen_tags.push_back(bus4.out_tag);
                    end
                end
                if (bus4.in_valid && bus4.in_ready) begin
                    m_full = ref_shift(4, bus4.in_inverse, {128'b0, bus4.in_state});
                    m_e.st  = m_full[127:0];
                    m_e.tag = bus4.in_tag;
                    sb_q.push_back(m_e);
                end
            end
        end
    end

    task automatic send4(input bit inv, input logic [127:0] st, input logic [TAG_W-1:0] tg);
        bit acc = 1'b0;
        bus4.in_valid   = 1'b1;
        bus4.in_inverse = inv;
        bus4.in_state   = st;
        bus4.in_tag     = tg;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            acc = bus4.in_ready;
            @(posedge clk);
            #1;
        end
        chk("send_accepted", acc, 1);
        bus4.in_valid = 1'b0;
    endtask

    task automatic beat_wide(input int unsigned nb, input bit inv, input logic [255:0] st,
                             input logic [TAG_W-1:0] tg, output logic [255:0] got);
        logic [255:0] exp;
        if (nb == 8) begin
            bus8.in_valid = 1'b1; bus8.in_inverse = inv; bus8.in_state = st; bus8.in_tag = tg;
        end else begin
            bus6.in_valid = 1'b1; bus6.in_inverse = inv; bus6.in_state = st[191:0]; bus6.in_tag = tg;
        end
        @(negedge clk);
        chk("wide_in_ready", (nb == 8) ? bus8.in_ready : bus6.in_ready, 1);
        @(posedge clk);
        #1;
        bus8.in_valid = 1'b0;
        bus6.in_valid = 1'b0;
        @(negedge clk);
        chk("wide_out_valid", (nb == 8) ? bus8.out_valid : bus6.out_valid, 1);
        chk("wide_out_tag", (nb == 8) ? bus8.out_tag : bus6.out_tag, tg);
        got = (nb == 8) ? bus8.out_state : {64'b0, bus6.out_state};
        exp = ref_shift(nb, inv, st);
        chk("wide_out_state", got, exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [255:0] got;
        logic [255:0] seq;
        bit           acc;
        int unsigned  acc_cnt;

        bus4.flush = 0; bus4.in_valid = 0; bus4.in_inverse = 0; bus4.in_state = '0;
        bus4.in_tag = '0; bus4.out_ready = 1;
        bus6.flush = 0; bus6.in_valid = 0; bus6.in_inverse = 0; bus6.in_state = '0;
        bus6.in_tag = '0; bus6.out_ready = 1;
        bus8.flush = 0; bus8.in_valid = 0; bus8.in_inverse = 0; bus8.in_state = '0;
        bus8.in_tag = '0; bus8.out_ready = 1;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", bus4.out_valid, 0);
        chk("reset_in_ready", bus4.in_ready, 1);
        chk("reset_out_state", bus4.out_state, 0);
        chk("reset_out_tag", bus4.out_tag, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_in_ready", bus4.in_ready, 1);
        @(posedge clk);
        #1;

        send4(1'b0, FIPS_IN, 4'h5);
        @(negedge clk);
        chk("fips_forward_state", bus4.out_state, FIPS_OUT);
        chk("fips_forward_tag", bus4.out_tag, 4'h5);
        @(posedge clk);
        #1;
        send4(1'b1, FIPS_OUT, 4'ha);
        @(negedge clk);
        chk("fips_inverse_state", bus4.out_state, FIPS_IN);
        chk("fips_inverse_tag", bus4.out_tag, 4'ha);
        @(posedge clk);
        #1;

        for (int unsigned i = 0; i < 8; i++)
            send4(i[0], i[0] ? FIPS_OUT : FIPS_IN, TAG_W'(i));
        repeat (3) @(posedge clk);
        #1;

        // Backpressure: three offered beats, only two fit.
        bus4.out_ready = 1'b0;
        seen_tags.delete();
        acc_cnt = 0;
        for (int unsigned t = 1; t <= 3; t++) begin
            bus4.in_valid = 1'b1; bus4.in_inverse = t[0]; bus4.in_state = rand128();
            bus4.in_tag = TAG_W'(t);
            @(negedge clk);
            if (t == 3) chk("full_in_ready_low", bus4.in_ready, 0);
            if (bus4.in_ready) acc_cnt++;
            @(posedge clk);
            #1;
        end
        chk("backpressure_accepted", acc_cnt, 2);
        bus4.out_ready = 1'b1;
        @(negedge clk);
        chk("in_ready_lags_release", bus4.in_ready, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("in_ready_after_release", bus4.in_ready, 1);
        @(posedge clk);
        #1;
        bus4.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("bp_seen_count", seen_tags.size(), 3);
        if (seen_tags.size() == 3) begin
            chk("bp_order_0", seen_tags[0], 1);
            chk("bp_order_1", seen_tags[1], 2);
            chk("bp_order_2", seen_tags[2], 3);
        end

        // Flush with both entries held and a beat offered in the flush cycle.
        bus4.out_ready = 1'b0;
        send4(1'b0, rand128(), 4'h6);
        send4(1'b1, rand128(), 4'h7);
        bus4.in_valid = 1'b1; bus4.in_state = rand128(); bus4.in_tag = 4'h9; bus4.flush = 1'b1;
        @(posedge clk);
        #1;
        bus4.flush = 1'b0;
        bus4.in_valid = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", bus4.out_valid, 0);
        chk("flush_in_ready", bus4.in_ready, 1);
        seen_tags.delete();
        bus4.out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("flush_nothing_emerges", seen_tags.size(), 0);

        // Random traffic with random backpressure and occasional flushes.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            acc = bus4.in_valid && bus4.in_ready;
            @(posedge clk);
            #1;
            if (!bus4.in_valid || acc) begin
                bus4.in_valid   = ($urandom % 4) != 0;
                bus4.in_inverse = $urandom % 2;
                bus4.in_state   = rand128();
                bus4.in_tag     = TAG_W'($urandom);
            end
            bus4.flush     = ($urandom % 40) == 0;
            bus4.out_ready = !bus4.flush && (($urandom % 3) != 0);
        end
        bus4.flush = 1'b0;
        bus4.in_valid = 1'b0;
        bus4.out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Reset mid-stream, between edges.
        bus4.in_valid = 1'b1; bus4.in_state = rand128(); bus4.in_tag = 4'h3;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midreset_out_valid", bus4.out_valid, 0);
        chk("midreset_out_state", bus4.out_state, 0);
        chk("midreset_out_tag", bus4.out_tag, 0);
        chk("midreset_in_ready", bus4.in_ready, 1);
        bus4.in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        seq = {128'b0, rand128()};
        send4(1'b1, seq[127:0], 4'hc);
        @(negedge clk);
        chk("post_reset_latency_valid", bus4.out_valid, 1);
        got = ref_shift(4, 1'b1, seq);
        chk("post_reset_latency_state", bus4.out_state, got[127:0]);
        @(posedge clk);
        #1;

        // Wide blocks: byte k holds value k, byte 0 at the MSBs.
        seq = '0;
        for (int unsigned k = 0; k < 32; k++) seq = (seq << 8) | 256'(k);
        beat_wide(8, 1'b0, seq, 4'h1, got);
        chk("nb8_col0", got[255 -: 32], 32'h00050e13);
        seq = '0;
        for (int unsigned k = 0; k < 24; k++) seq = (seq << 8) | 256'(k);
        beat_wide(6, 1'b0, seq, 4'h2, got);
        chk("nb6_col0", got[191 -: 32], 32'h00050a0f);
        for (int i = 0; i < 6; i++) begin
            beat_wide(8, $urandom % 2, {rand128(), rand128()}, TAG_W'($urandom), got);
            beat_wide(6, $urandom % 2, {64'b0, 64'({$urandom, $urandom}), rand128()},
                      TAG_W'($urandom), got);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
